reg_commit_ctrl: RTL and testbench

REG_COMMIT_CTRL -- requirements
Module: reg_commit_ctrl

---
 rtl/reg_commit_ctrl_pkg.sv | 22 ++
 rtl/reg_commit_ctrl.sv | 155 +++++++++++++++
 tb/tb_reg_commit_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_commit_ctrl_pkg.sv
// Shared constants for the commit controller: data/register/tag widths,
// reset values and the FSM state encoding.
package reg_commit_ctrl_pkg;

    localparam int ROB_W_DEF   = 4;   // default ROB tag width
    localparam int REG_W       = 5;   // architectural register index width
    localparam int DATA_W      = 32;  // result / PC width
    localparam int CNT_W       = 32;  // retired-entry counter width
    localparam int FLUSH_CNT_W = 4;   // holds FLUSH_CYCLES up to 15

    localparam logic [REG_W-1:0]       RD_RST    = '0;
    localparam logic [DATA_W-1:0]      DATA_RST  = '0;
    localparam logic [CNT_W-1:0]       COUNT_RST = '0;
    localparam logic [FLUSH_CNT_W-1:0] FCNT_RST  = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        RESUME = 2'd2
    } state_t;

endpackage

// File: rtl/reg_commit_ctrl.sv
// In-order commit controller: retires the ROB head into the register file,
// and on a mispredicted head runs a rollback sequence
// (FLUSH with rollback_flag held, then one quiet RESUME cycle) while
// stalling dispatch and redirecting fetch.
//
// Handshake: head_pop is the only ready-side signal. An entry is consumed on
// a rising edge exactly when head_pop is high, i.e. IDLE, rdy_in, head_valid
// and head_ready are all high in the cycle before that edge.
//
// Mispredict timeline for FLUSH_CYCLES = N (cycle 1 = first after the pop):
//   cycle 1         : FLUSH, commit_flag and pc_redirect_valid pulse
//   cycles 2..N+1   : FLUSH, rollback_flag = 1
//   cycle N+2       : RESUME, rollback_flag = 0
//   stall_dispatch is high over cycles 1..N+2.
module reg_commit_ctrl
    import reg_commit_ctrl_pkg::*;
#(
    parameter int ROB_W        = ROB_W_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              head_valid,
    input  logic              head_ready,
    input  logic [ROB_W-1:0]  head_rob_id,
    input  logic [REG_W-1:0]  head_rd,
    input  logic [DATA_W-1:0] head_value,
    input  logic              head_mispredict,
    input  logic [DATA_W-1:0] head_target_pc,
    output logic              head_pop,
    output logic              commit_flag,
    output logic [REG_W-1:0]  rd_to_reg,
    output logic [DATA_W-1:0] V_to_reg,
    output logic [ROB_W-1:0]  Q_to_reg,
    output logic              rollback_flag,
    output logic              pc_redirect_valid,
    output logic [DATA_W-1:0] pc_redirect,
    output logic              stall_dispatch,
    output logic [CNT_W-1:0]  commit_count,
    output logic [1:0]        dbg_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] FCNT_ONE   = FLUSH_CNT_W'(1);

    state_t                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   commit_flag_q, commit_flag_d;
    logic [REG_W-1:0]       rd_q, rd_d;
    logic [DATA_W-1:0]      v_q, v_d;
    logic [ROB_W-1:0]       tag_q, tag_d;
    logic                   rollback_q, rollback_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0]      redirect_q, redirect_d;
    logic                   stall_q, stall_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pop;

    // Pop decision plus next-state / next-output computation; everything
    // holds when rdy_in is low.
    always_comb begin
        pop              = (state_q == IDLE) && rdy_in && head_valid && head_ready;
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        commit_flag_d    = commit_flag_q;
        rd_d             = rd_q;
        v_d              = v_q;
        tag_d            = tag_q;
        rollback_d       = rollback_q;
        redirect_valid_d = redirect_valid_q;
        redirect_d       = redirect_q;
        stall_d          = stall_q;
        count_d          = count_q;
        if (rdy_in) begin
            commit_flag_d    = 1'b0;
            redirect_valid_d = 1'b0;
            rollback_d       = 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        commit_flag_d = 1'b1;
                        rd_d          = head_rd;
                        v_d           = head_value;
                        tag_d         = head_rob_id;
                        count_d       = count_q + 32'd1;
                        if (head_mispredict) begin
                            state_d          = FLUSH;
                            flush_cnt_d      = FLUSH_LOAD;
                            redirect_valid_d = 1'b1;
                            redirect_d       = head_target_pc;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q != FCNT_RST) begin
                        rollback_d  = 1'b1;
                        flush_cnt_d = flush_cnt_q - FCNT_ONE;
                    end else begin
                        state_d = RESUME;
                    end
                end
                RESUME: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            stall_d = (state_d != IDLE);
        end
    end

    // FSM state, flush counter and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= IDLE;
            flush_cnt_q      <= FCNT_RST;
            commit_flag_q    <= 1'b0;
            rd_q             <= RD_RST;
            v_q              <= DATA_RST;
            tag_q            <= '0;
            rollback_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_q       <= DATA_RST;
            stall_q          <= 1'b0;
            count_q          <= COUNT_RST;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            commit_flag_q    <= commit_flag_d;
            rd_q             <= rd_d;
            v_q              <= v_d;
            tag_q            <= tag_d;
            rollback_q       <= rollback_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_q       <= redirect_d;
            stall_q          <= stall_d;
            count_q          <= count_d;
        end
    end

    assign head_pop          = pop;
    assign commit_flag       = commit_flag_q;
    assign rd_to_reg         = rd_q;
    assign V_to_reg          = v_q;
    assign Q_to_reg          = tag_q;
    assign rollback_flag     = rollback_q;
    assign pc_redirect_valid = redirect_valid_q;
    assign pc_redirect       = redirect_q;
    assign stall_dispatch    = stall_q;
    assign commit_count      = count_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// Bench for reg_commit_ctrl: directed scenarios plus a randomized run, all
// checked against a cycle-indexed reference model of the commit/rollback
// behaviour.
module tb_reg_commit_ctrl;
    import reg_commit_ctrl_pkg::*;

    localparam int F  = 2;
    localparam int RW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_in;
    logic              rdy_in, head_valid, head_ready, head_mispredict;
    logic [RW-1:0]     head_rob_id;
    logic [4:0]        head_rd;
    logic [31:0]       head_value, head_target_pc;
    logic              head_pop, commit_flag, rollback_flag, pc_redirect_valid, stall_dispatch;
    logic [4:0]        rd_to_reg;
    logic [31:0]       V_to_reg, pc_redirect, commit_count;
    logic [RW-1:0]     Q_to_reg;
    logic [1:0]        dbg_state;

    reg_commit_ctrl #(.ROB_W(RW), .FLUSH_CYCLES(F)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_ready(head_ready),
        .head_rob_id(head_rob_id), .head_rd(head_rd), .head_value(head_value),
        .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
        .head_pop(head_pop), .commit_flag(commit_flag), .rd_to_reg(rd_to_reg),
        .V_to_reg(V_to_reg), .Q_to_reg(Q_to_reg), .rollback_flag(rollback_flag),
        .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
        .stall_dispatch(stall_dispatch), .commit_count(commit_count),
        .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // m_k = 0 when normal; otherwise the index of the current cycle after a
    // mispredict pop (1 .. F+2). Outputs derive from that index directly.
    int          m_k;
    logic        m_commit;
    logic [4:0]  m_rd;
    logic [31:0] m_v, m_pc, m_cnt;
    logic [RW-1:0] m_q;

    function automatic void model_reset();
        m_k = 0; m_commit = 1'b0; m_rd = '0; m_v = '0; m_q = '0; m_pc = '0; m_cnt = '0;
    endfunction

    function automatic logic model_pop();
        return (m_k == 0) && rdy_in && head_valid && head_ready;
    endfunction
    function automatic logic model_rollback();
        return (m_k >= 2) && (m_k <= F + 1);
    endfunction
    function automatic logic model_redirect_valid();
        return (m_k == 1);
    endfunction
    function automatic logic model_stall();
        return (m_k != 0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic rdy, input logic hv, input logic hr, input logic mp,
                          input logic [RW-1:0] id, input logic [4:0] rd,
                          input logic [31:0] val, input logic [31:0] tpc);
        @(negedge clk);
        rdy_in = rdy; head_valid = hv; head_ready = hr; head_mispredict = mp;
        head_rob_id = id; head_rd = rd; head_value = val; head_target_pc = tpc;
        #1;
    endtask

    // Advance one clock edge and step the model with the inputs seen at it.
    task automatic tick();
        logic pop;
        pop = model_pop();
        @(posedge clk);
        if (rdy_in) begin
            m_commit = pop;
            if (pop) begin
                m_rd = head_rd; m_v = head_value; m_q = head_rob_id; m_cnt = m_cnt + 32'd1;
            end
            if (pop && head_mispredict) begin
                m_pc = head_target_pc;
                m_k  = 1;
            end else if (m_k == F + 2) begin
                m_k = 0;
            end else if (m_k != 0) begin
                m_k = m_k + 1;
            end
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1; head_valid = 1'b0; head_ready = 1'b0; head_mispredict = 1'b0;
        head_rob_id = '0; head_rd = '0; head_value = '0; head_target_pc = '0;
        model_reset();
        #2;
        n_vec++; if (commit_flag !== 1'b0) begin n_bad++; $display("FAIL reset commit_flag got %0b want 0", commit_flag); end
        n_vec++; if (rollback_flag !== 1'b0) begin n_bad++; $display("FAIL reset rollback_flag got %0b want 0", rollback_flag); end
        n_vec++; if (stall_dispatch !== 1'b0) begin n_bad++; $display("FAIL reset stall got %0b want 0", stall_dispatch); end
        n_vec++; if (pc_redirect_valid !== 1'b0) begin n_bad++; $display("FAIL reset redirect_valid got %0b want 0", pc_redirect_valid); end
        n_vec++; if ({rd_to_reg, V_to_reg, Q_to_reg, pc_redirect, commit_count} !== '0) begin
            n_bad++; $display("FAIL reset data rd=%0d V=%h Q=%0d pc=%h cnt=%0d want all 0", rd_to_reg, V_to_reg, Q_to_reg, pc_redirect, commit_count);
        end
        n_vec++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset state got %0d want %0d", dbg_state, IDLE); end
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic test_basic_commit();
        set_in(1, 1, 1, 0, 4'd3, 5'd5, 32'h1234, 32'h0);
        n_vec++; if (head_pop !== 1'b1) begin n_bad++; $display("FAIL basic head_pop got %0b want 1", head_pop); end
        tick();
        n_vec++; if (commit_flag !== 1'b1) begin n_bad++; $display("FAIL basic commit_flag got %0b want 1", commit_flag); end
        n_vec++; if (rd_to_reg !== 5'd5) begin n_bad++; $display("FAIL basic rd got %0d want 5", rd_to_reg); end
        n_vec++; if (V_to_reg !== 32'h1234) begin n_bad++; $display("FAIL basic V got %h want 1234", V_to_reg); end
        n_vec++; if (Q_to_reg !== 4'd3) begin n_bad++; $display("FAIL basic Q got %0d want 3", Q_to_reg); end
        n_vec++; if (commit_count !== 32'd1) begin n_bad++; $display("FAIL basic count got %0d want 1", commit_count); end
        set_in(1, 0, 0, 0, 4'd9, 5'd9, 32'hdead, 32'h0);
        tick();
        n_vec++; if (commit_flag !== 1'b0) begin n_bad++; $display("FAIL basic pulse commit_flag got %0b want 0", commit_flag); end
        n_vec++; if ({rd_to_reg, V_to_reg, Q_to_reg} !== {5'd5, 32'h1234, 4'd3}) begin
            n_bad++; $display("FAIL basic hold rd=%0d V=%h Q=%0d want 5 1234 3", rd_to_reg, V_to_reg, Q_to_reg);
        end
        // Entry with no destination still commits.
        set_in(1, 1, 1, 0, 4'd7, 5'd0, 32'h55, 32'h0);
        tick();
        n_vec++; if (commit_flag !== 1'b1 || rd_to_reg !== 5'd0) begin
            n_bad++; $display("FAIL rd0 commit got flag=%0b rd=%0d want 1 0", commit_flag, rd_to_reg);
        end
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
    endtask

    task automatic test_not_ready();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 0, 0, 4'd2, 5'd3, 32'hbeef, 32'h0);
            n_vec++; if (head_pop !== 1'b0) begin n_bad++; $display("FAIL notready head_pop cyc %0d got %0b want 0", i, head_pop); end
            tick();
            n_vec++; if (commit_flag !== 1'b0) begin n_bad++; $display("FAIL notready commit_flag cyc %0d got %0b want 0", i, commit_flag); end
        end
    endtask

    task automatic test_mispredict();
        logic [3:0] e_commit, e_redir, e_roll, e_stall;
        e_commit = 4'b0001; e_redir = 4'b0001; e_roll = 4'b0110; e_stall = 4'b1111;
        set_in(1, 1, 1, 1, 4'd4, 5'd6, 32'h77, 32'h100);
        n_vec++; if (head_pop !== 1'b1) begin n_bad++; $display("FAIL mp head_pop got %0b want 1", head_pop); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (commit_flag !== e_commit[i]) begin n_bad++; $display("FAIL mp commit cyc %0d got %0b want %0b", i + 1, commit_flag, e_commit[i]); end
            n_vec++; if (pc_redirect_valid !== e_redir[i]) begin n_bad++; $display("FAIL mp redirect_valid cyc %0d got %0b want %0b", i + 1, pc_redirect_valid, e_redir[i]); end
            n_vec++; if (rollback_flag !== e_roll[i]) begin n_bad++; $display("FAIL mp rollback cyc %0d got %0b want %0b", i + 1, rollback_flag, e_roll[i]); end
            n_vec++; if (stall_dispatch !== e_stall[i]) begin n_bad++; $display("FAIL mp stall cyc %0d got %0b want %0b", i + 1, stall_dispatch, e_stall[i]); end
            n_vec++; if (pc_redirect !== 32'h100) begin n_bad++; $display("FAIL mp pc_redirect cyc %0d got %h want 100", i + 1, pc_redirect); end
            set_in(1, 1, 1, 0, 4'd5, 5'd1, 32'h88, 32'h0);
            n_vec++; if (head_pop !== 1'b0) begin n_bad++; $display("FAIL mp head_pop cyc %0d got %0b want 0", i + 1, head_pop); end
            tick();
        end
        n_vec++; if (stall_dispatch !== 1'b0 || rollback_flag !== 1'b0) begin
            n_bad++; $display("FAIL mp end stall=%0b rollback=%0b want 0 0", stall_dispatch, rollback_flag);
        end
        n_vec++; if (head_pop !== 1'b1) begin n_bad++; $display("FAIL mp resume head_pop got %0b want 1", head_pop); end
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
    endtask

    task automatic test_rdy_freeze();
        set_in(1, 1, 1, 1, 4'd1, 5'd2, 32'h99, 32'h240);
        tick();
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
        n_vec++; if (rollback_flag !== 1'b1) begin n_bad++; $display("FAIL freeze pre rollback got %0b want 1", rollback_flag); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 0, 4'd2, 5'd2, 32'h1, 32'h0);
            n_vec++; if (head_pop !== 1'b0) begin n_bad++; $display("FAIL freeze head_pop cyc %0d got %0b want 0", i, head_pop); end
            tick();
            n_vec++; if (rollback_flag !== 1'b1 || stall_dispatch !== 1'b1) begin
                n_bad++; $display("FAIL freeze hold cyc %0d rollback=%0b stall=%0b want 1 1", i, rollback_flag, stall_dispatch);
            end
            n_vec++; if (commit_flag !== 1'b0 || pc_redirect_valid !== 1'b0) begin
                n_bad++; $display("FAIL freeze pulses cyc %0d commit=%0b redir=%0b want 0 0", i, commit_flag, pc_redirect_valid);
            end
        end
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
        n_vec++; if (rollback_flag !== 1'b1) begin n_bad++; $display("FAIL freeze remaining rollback got %0b want 1", rollback_flag); end
        tick();
        n_vec++; if (rollback_flag !== 1'b0 || stall_dispatch !== 1'b1) begin
            n_bad++; $display("FAIL freeze resume rollback=%0b stall=%0b want 0 1", rollback_flag, stall_dispatch);
        end
        tick();
        n_vec++; if (stall_dispatch !== 1'b0) begin n_bad++; $display("FAIL freeze idle stall got %0b want 0", stall_dispatch); end
    endtask

    task automatic test_reset_mid_flush();
        set_in(1, 1, 1, 1, 4'd6, 5'd4, 32'h42, 32'h300);
        tick();
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
        #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        n_vec++; if ({commit_flag, rollback_flag, pc_redirect_valid, stall_dispatch} !== 4'b0) begin
            n_bad++; $display("FAIL midrst flags commit=%0b roll=%0b redir=%0b stall=%0b want 0", commit_flag, rollback_flag, pc_redirect_valid, stall_dispatch);
        end
        n_vec++; if ({rd_to_reg, V_to_reg, Q_to_reg, pc_redirect, commit_count} !== '0) begin
            n_bad++; $display("FAIL midrst data rd=%0d V=%h Q=%0d pc=%h cnt=%0d want 0", rd_to_reg, V_to_reg, Q_to_reg, pc_redirect, commit_count);
        end
        n_vec++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL midrst state got %0d want %0d", dbg_state, IDLE); end
        @(negedge clk);
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (rollback_flag !== 1'b0 || stall_dispatch !== 1'b0) begin
                n_bad++; $display("FAIL midrst residual cyc %0d rollback=%0b stall=%0b want 0 0", i, rollback_flag, stall_dispatch);
            end
        end
    endtask

    task automatic test_count_wrap();
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        force dut.count_q = 32'hFFFF_FFFD;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFF_FFFD;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 0, 4'(i), 5'(i + 1), 32'(i), 32'h0);
            tick();
            n_vec++; if (commit_count !== m_cnt) begin n_bad++; $display("FAIL wrap count step %0d got %h want %h", i, commit_count, m_cnt); end
        end
        n_vec++; if (commit_count !== 32'h0) begin n_bad++; $display("FAIL wrap final count got %h want 0", commit_count); end
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 5) == 0, 4'($urandom), 5'($urandom), $urandom, $urandom);
            n_vec++; if (head_pop !== model_pop()) begin n_bad++; $display("FAIL rnd head_pop cyc %0d got %0b want %0b", c, head_pop, model_pop()); end
            tick();
            n_vec++; if (commit_flag !== m_commit) begin n_bad++; $display("FAIL rnd commit_flag cyc %0d got %0b want %0b", c, commit_flag, m_commit); end
            n_vec++; if (rd_to_reg !== m_rd) begin n_bad++; $display("FAIL rnd rd cyc %0d got %0d want %0d", c, rd_to_reg, m_rd); end
            n_vec++; if (V_to_reg !== m_v) begin n_bad++; $display("FAIL rnd V cyc %0d got %h want %h", c, V_to_reg, m_v); end
            n_vec++; if (Q_to_reg !== m_q) begin n_bad++; $display("FAIL rnd Q cyc %0d got %0d want %0d", c, Q_to_reg, m_q); end
            n_vec++; if (rollback_flag !== model_rollback()) begin n_bad++; $display("FAIL rnd rollback cyc %0d got %0b want %0b", c, rollback_flag, model_rollback()); end
            n_vec++; if (pc_redirect_valid !== model_redirect_valid()) begin n_bad++; $display("FAIL rnd redirect_valid cyc %0d got %0b want %0b", c, pc_redirect_valid, model_redirect_valid()); end
            n_vec++; if (pc_redirect !== m_pc) begin n_bad++; $display("FAIL rnd pc_redirect cyc %0d got %h want %h", c, pc_redirect, m_pc); end
            n_vec++; if (stall_dispatch !== model_stall()) begin n_bad++; $display("FAIL rnd stall cyc %0d got %0b want %0b", c, stall_dispatch, model_stall()); end
            n_vec++; if (commit_count !== m_cnt) begin n_bad++; $display("FAIL rnd count cyc %0d got %0d want %0d", c, commit_count, m_cnt); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_commit();
        test_not_ready();
        test_mispredict();
        test_rdy_freeze();
        test_reset_mid_flush();
        test_count_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
